// File: rtl/req_rr_arbiter.sv
// Round-robin request collector: latches request pulses into a pending vector and
// offers one registered, stable grant at a time over a valid/ready handshake.
`timescale 1ns/1ps

module req_rr_arbiter #(
   parameter int NUM_REQ = 14,
   parameter int IDX_W   = 4
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               clear,
   input  logic [NUM_REQ-1:0] req_set_vec,
   output logic [NUM_REQ-1:0] pending_vec,
   output logic               grant_valid,
   input  logic               grant_ready,
   output logic [IDX_W-1:0]   grant_index,
   output logic [NUM_REQ-1:0] grant_one_hot,
   output logic [IDX_W-1:0]   rr_ptr
);

   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic               valid_q, valid_d;
   logic [IDX_W-1:0]   index_q, index_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;

   logic               hs;
   logic [NUM_REQ-1:0] acc_vec;
   logic [NUM_REQ-1:0] ge_ptr_mask;
   logic [NUM_REQ-1:0] upper_vec;
   logic [IDX_W-1:0]   sel_index;
   logic               sel_any;

   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
      lowest_set = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            lowest_set = IDX_W'(i);
         end
      end
   endfunction

   assign hs = valid_q & grant_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_per_src
         assign acc_vec[gi]       = hs && (index_q == IDX_W'(gi));
         assign ge_ptr_mask[gi]   = (IDX_W'(gi) >= ptr_d);
         assign grant_one_hot[gi] = valid_q && (index_q == IDX_W'(gi));
      end
   endgenerate

   // The pointer advances on every accept, even one that coincides with clear.
   always_comb begin
      ptr_d = ptr_q;
      if (hs) begin
         ptr_d = (index_q == IDX_W'(NUM_REQ - 1)) ? '0 : index_q + IDX_W'(1);
      end
   end

   always_comb begin
      pending_d = (pending_q & ~acc_vec) | req_set_vec;
      if (clear) begin
         pending_d = '0;
      end
   end

   // Search from the post-update pointer upward, wrapping to the lowest index.
   assign upper_vec = pending_d & ge_ptr_mask;
   assign sel_any   = |pending_d;
   assign sel_index = (|upper_vec) ? lowest_set(upper_vec) : lowest_set(pending_d);

   always_comb begin
      valid_d = valid_q;
      index_d = index_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (!valid_q || hs) begin
         valid_d = sel_any;
         if (sel_any) begin
            index_d = sel_index;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pending_q <= '0;
         valid_q   <= 1'b0;
         index_q   <= '0;
         ptr_q     <= '0;
      end else begin
         pending_q <= pending_d;
         valid_q   <= valid_d;
         index_q   <= index_d;
         ptr_q     <= ptr_d;
      end
   end

   assign pending_vec = pending_q;
   assign grant_valid = valid_q;
   assign grant_index = index_q;
   assign rr_ptr      = ptr_q;

endmodule

// File: tb/tb_req_rr_arbiter.sv
// Randomized and directed bench for req_rr_arbiter: a driver issues stimulus and
// queues expected state/accepts from a circular-search reference model; a monitor checks.
`timescale 1ns/1ps

module tb_req_rr_arbiter;
   localparam int N = 14;
   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         nRST = 1'b0;
   logic         clear = 1'b0;
   logic [N-1:0] req_set_vec = '0;
   logic         grant_ready = 1'b0;
   logic [N-1:0] pending_vec;
   logic         grant_valid;
   logic [W-1:0] grant_index;
   logic [N-1:0] grant_one_hot;
   logic [W-1:0] rr_ptr;

   req_rr_arbiter #(.NUM_REQ(N), .IDX_W(W)) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .clear        (clear),
      .req_set_vec  (req_set_vec),
      .pending_vec  (pending_vec),
      .grant_valid  (grant_valid),
      .grant_ready  (grant_ready),
      .grant_index  (grant_index),
      .grant_one_hot(grant_one_hot),
      .rr_ptr       (rr_ptr)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic         valid;
      logic [W-1:0] idx;
      logic [W-1:0] ptr;
      logic [N-1:0] pend;
   } snap_t;

   snap_t snap_q[$];
   int    acc_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   // Reference model state: plain arrays and integers
   bit m_pend[N];
   bit m_valid;
   int m_idx;
   int m_ptr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic snap_t model_snap();
      snap_t s;
      s.valid = m_valid;
      s.idx   = W'(m_idx);
      s.ptr   = W'(m_ptr);
      for (int i = 0; i < N; i++) s.pend[i] = m_pend[i];
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
   endtask

   // One clock of stimulus; the model advances to what the DUT should show next cycle.
   task automatic step(input logic [N-1:0] req, input logic rdy, input logic clr);
      bit hs;
      int j;
      @(posedge CLK);
      #1;
      snap_q.push_back(model_snap());
      req_set_vec = req;
      grant_ready = rdy;
      clear       = clr;
      hs = m_valid && rdy;
      if (hs) begin
         acc_q.push_back(m_idx);
         m_ptr = (m_idx + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         m_pend[i] = clr ? 1'b0 : ((m_pend[i] && !(hs && i == m_idx)) || req[i]);
      end
      if (clr) begin
         m_valid = 1'b0;
      end else if (!m_valid || hs) begin
         m_valid = 1'b0;
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!m_valid && m_pend[j]) begin
               m_valid = 1'b1;
               m_idx   = j;
            end
         end
      end
   endtask

   task automatic expect_now(input string name, input logic v, input int idx, input int ptr);
      check({name, ".valid"}, grant_valid, v);
      check({name, ".index"}, grant_index, idx);
      check({name, ".rr_ptr"}, rr_ptr, ptr);
   endtask

   task automatic do_async_reset();
      @(negedge CLK);
      #2;
      nRST        = 1'b0;
      req_set_vec = '0;
      grant_ready = 1'b0;
      clear       = 1'b0;
      #1;
      check("rst.pending", pending_vec, 0);
      check("rst.valid", grant_valid, 0);
      check("rst.index", grant_index, 0);
      check("rst.one_hot", grant_one_hot, 0);
      check("rst.rr_ptr", rr_ptr, 0);
      model_reset();
      acc_q.delete();
      @(posedge CLK);
      @(negedge CLK);
      #2;
      nRST = 1'b1;
   endtask

   // Monitor: compares every cycle's state and each accepted grant.
   initial begin
      snap_t s;
      int    e;
      forever begin
         @(negedge CLK);
         if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            check("mon.valid", grant_valid, s.valid);
            check("mon.index", grant_index, s.idx);
            check("mon.rr_ptr", rr_ptr, s.ptr);
            check("mon.pending", pending_vec, s.pend);
            check("mon.one_hot", grant_one_hot, s.valid ? (32'd1 << s.idx) : 32'd0);
         end
         if (nRST && grant_valid && grant_ready) begin
            if (acc_q.size() == 0) begin
               check("mon.unexpected_accept", grant_index, 32'hFFFF);
            end else begin
               e = acc_q.pop_front();
               check("mon.accept_index", grant_index, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] r;
      model_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("init.pending", pending_vec, 0);
      check("init.valid", grant_valid, 0);
      check("init.one_hot", grant_one_hot, 0);
      check("init.rr_ptr", rr_ptr, 0);
      #2;
      nRST = 1'b1;

      // Idle
      for (int i = 0; i < 5; i++) begin
         step('0, 1'b1, 1'b0);
         expect_now("idle", 1'b0, 0, 0);
      end

      // Two-bit pulse: 2 then 5
      step(14'b00_0000_0010_0100, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      expect_now("pulse.c1", 1'b1, 2, 0);
      step('0, 1'b1, 1'b0);
      expect_now("pulse.c2", 1'b1, 5, 3);
      step('0, 1'b1, 1'b0);
      expect_now("pulse.c3", 1'b0, 5, 6);
      do_async_reset();

      // All sources pending, consumer always ready
      step({N{1'b1}}, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) begin
         step('0, 1'b1, 1'b0);
         expect_now("all14", 1'b1, i, i);
      end
      step('0, 1'b1, 1'b0);
      expect_now("all14.end", 1'b0, 13, 0);

      // Stall on 9 with 3 pending and bit 0 arriving, then wrap to 0, then 3
      step(14'h0200, 1'b0, 1'b0);
      step(14'h0008, 1'b0, 1'b0);
      expect_now("stall.offer", 1'b1, 9, 0);
      for (int i = 0; i < 4; i++) begin
         step(14'h0001, 1'b0, 1'b0);
         expect_now("stall.hold", 1'b1, 9, 0);
      end
      step('0, 1'b1, 1'b0);
      expect_now("stall.acc9", 1'b1, 9, 0);
      step('0, 1'b1, 1'b0);
      expect_now("stall.wrap0", 1'b1, 0, 10);
      step('0, 1'b1, 1'b0);
      expect_now("stall.then3", 1'b1, 3, 1);

      // Accept and re-set of the same source: set wins
      step(14'h0010, 1'b0, 1'b0);
      expect_now("same.idle", 1'b0, 3, 4);
      step(14'h0010, 1'b1, 1'b0);
      expect_now("same.offer", 1'b1, 4, 4);
      step('0, 1'b0, 1'b0);
      expect_now("same.regrant", 1'b1, 4, 5);
      check("same.pending", pending_vec, 14'h0010);

      // Clear with pending {1,7} and a simultaneous set of bit 2
      step(14'h0082, 1'b1, 1'b0);
      step(14'h0004, 1'b0, 1'b1);
      expect_now("clr.before", 1'b1, 7, 5);
      check("clr.pending_before", pending_vec, 14'h0082);
      step('0, 1'b0, 1'b0);
      expect_now("clr.after", 1'b0, 7, 5);
      check("clr.pending_after", pending_vec, 0);

      // Reset in the middle of a stall
      step(14'h0008, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      expect_now("rststall", 1'b1, 3, 5);
      do_async_reset();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
         step(r, ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
         if (i == 1500) do_async_reset();
      end

      step('0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      @(negedge CLK);
      #1;
      check("end.pending_accepts", acc_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/req_rr_arbiter.md
Name: req_rr_arbiter

Overview:
- 14-source request collector and round-robin grant stage that sits directly upstream of the priority one-hot select block.
- Latches request pulses into a pending vector and holds each until it is granted.
- Rotates a priority base pointer so that no source starves.
- Offers one registered, stable grant at a time over a valid/ready handshake to the downstream consumer.

Parameters:
- NUM_REQ, 14, number of request sources.
- IDX_W, 4, width of the grant index; must satisfy 2^IDX_W >= NUM_REQ.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset; asynchronous, active-low.
- clear  input  1  synchronous flush of all pending and offered state.
- req_set_vec  input  NUM_REQ  one cycle per bit; a 1 marks that source as pending.
- pending_vec  output  NUM_REQ  registered pending requests, including the one currently offered.
- grant_valid  output  1  registered; a grant is offered.
- grant_ready  input  1  the consumer accepts the offered grant.
- grant_index  output  IDX_W  registered index of the offered source.
- grant_one_hot  output  NUM_REQ  one-hot of grant_index, gated by grant_valid (all zeros when grant_valid=0).
- rr_ptr  output  IDX_W  registered round-robin base pointer, for debug and verification.

Behaviour:
- Clocking and reset:
  - One clock, CLK.
  - Reset is asynchronous and active-low on nRST. While nRST=0, pending_vec=0, grant_valid=0, grant_index=0, grant_one_hot=0, rr_ptr=0.
  - Asserting reset in the middle of a handshake discards all state; nothing is retained.
- Handshake:
  - A handshake (hs) occurs when grant_valid && grant_ready.
  - grant_ready is ignored while grant_valid=0.
  - While grant_valid=1 and grant_ready=0, grant_index and grant_valid hold stable, independent of any new requests.
- Pending update:
  - acc = hs ? onehot(grant_index) : 0.
  - pending_next = (pending_vec & ~acc) | req_set_vec.
  - If a set and an accept hit the same bit in the same cycle, the set wins and the source stays pending.
  - Re-setting a bit that is already pending has no effect; requests do not count.
- Pointer update:
  - On hs, rr_ptr <= (grant_index == NUM_REQ-1) ? 0 : grant_index+1.
  - Otherwise rr_ptr holds.
  - rr_ptr never takes a value >= NUM_REQ.
- Selection:
  - Selection is evaluated only when grant_valid=0 or hs.
  - Pick the lowest set index >= ptr_next in pending_next, where ptr_next is the post-update pointer. If there is none, pick the lowest set index overall (wrap-around).
  - If pending_next is 0, the next grant_valid is 0 and grant_index holds its old value.
  - Otherwise the next grant_valid is 1 and grant_index takes the selected index.
  - Because selection only runs under these conditions, the currently offered entry cannot be re-selected while it is still unaccepted.
- Latency:
  - A req_set in cycle N into an idle block gives grant_valid=1 in cycle N+1.
  - After a hs in cycle N, the next grant is offered in cycle N+1, so back-to-back grants are possible every cycle.
- Clear:
  - When clear=1, the next state is pending_vec=0 and grant_valid=0.
  - req_set_vec and any hs in the same cycle are dropped.
  - rr_ptr updates as it normally would if hs=1.
  - clear takes priority over everything except nRST.

Test Plan:
- Reset, then req_set_vec=14'h0000 for 5 cycles -> grant_valid=0, pending_vec=0, rr_ptr=0 throughout.
- Pulse req_set_vec=14'b00_0000_0010_0100 in cycle 0 with grant_ready=1 -> cycle 1: grant_index=2; cycle 2: grant_index=5, rr_ptr=3; cycle 3: grant_valid=0, rr_ptr=6.
- With all 14 bits pending and grant_ready=1 constantly -> indices 0,1,...,13 granted on consecutive cycles, then rr_ptr wraps to 0 and grant_valid=0.
- Pending={3,9}, offered index 9, grant_ready=0 for 4 cycles while req_set_vec sets bit 0 -> grant_index stays 9. Then raise ready -> 9 accepted, rr_ptr=10, next grant is index 0 (wrap-around), then index 3.
- Offered index 4 accepted while req_set_vec bit 4 is set in the same cycle -> pending_vec[4] stays 1 and rr_ptr=5. With no other pending source, index 4 is re-granted the next cycle.
- Pending={1,7} with grant_valid=1, assert clear together with req_set bit 2 -> next cycle pending_vec=0, grant_valid=0; bit 2 is dropped. Also assert nRST low in the middle of a stall -> all outputs go to 0 immediately.
